raw10_unpack: RTL and testbench

//  Unpacks the CSI-2 RAW10 byte stream from the lane aligner/depacketizer into 10-bit pixels.

---
 rtl/raw10_unpack_if.sv | 33 +++
 rtl/raw10_unpack.sv | 79 +++++++
 tb/tb_raw10_unpack.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/raw10_unpack_if.sv
// RAW10 byte-stream input and pixel-group output bundle.
// master drives the byte beats; slave is the unpacker.
interface raw10_unpack_if #(
  parameter int NUM_LANE = 4
) ();
  logic [8*NUM_LANE-1:0] in_data;
  logic                  in_valid;
  logic                  in_line_end;
  logic [39:0]           out_pix;
  logic                  out_valid;
  logic                  out_line_end;
  logic                  err_partial;

  modport master (
    output in_data,
    output in_valid,
    output in_line_end,
    input  out_pix,
    input  out_valid,
    input  out_line_end,
    input  err_partial
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_line_end,
    output out_pix,
    output out_valid,
    output out_line_end,
    output err_partial
  );
endinterface

// File: rtl/raw10_unpack.sv
// CSI-2 RAW10 unpacker: 5 payload bytes -> 4 ten-bit pixels.
// Rate-adapts NUM_LANE bytes/cycle, at most one group per cycle.
module raw10_unpack #(
  parameter int NUM_LANE = 4
) (
  input  logic           clk,
  input  logic           rst,
  raw10_unpack_if.slave  bus
);
  localparam int         PIX_W = 10;
  localparam logic [3:0] NL    = 4'(NUM_LANE);

  logic [7:0]         byte_q [9];
  logic [3:0]         cnt_q;
  logic [7:0]         mrg [9];
  logic [3:0]         tot;
  logic [3:0]         rem;
  logic               take;
  logic [4*PIX_W-1:0] grp;

  logic [4*PIX_W-1:0] pix_q;
  logic               vld_q;
  logic               le_q;
  logic               err_q;

  // new lanes land right after the buffered bytes
  always_comb begin
    for (int j = 0; j < 9; j++) begin
      mrg[j] = byte_q[j];
      for (int k = 0; k < NUM_LANE; k++) begin
        if (4'(j) == cnt_q + 4'(k)) begin
          mrg[j] = bus.in_data[8*k +: 8];
        end
      end
    end
    tot  = cnt_q + NL;
    take = (tot >= 4'd5);
    rem  = take ? tot - 4'd5 : tot;
    for (int n = 0; n < 4; n++) begin
      grp[PIX_W*n +: PIX_W] = {mrg[n], mrg[4][2*n +: 2]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pix_q <= '0;
      vld_q <= 1'b0;
      le_q  <= 1'b0;
      err_q <= 1'b0;
      for (int j = 0; j < 9; j++) begin
        byte_q[j] <= '0;
      end
    end else begin
      vld_q <= bus.in_valid & take;
      le_q  <= bus.in_valid & bus.in_line_end;
      err_q <= bus.in_valid & bus.in_line_end
               & (rem != 4'd0);
      if (bus.in_valid) begin
        if (take) begin
          pix_q <= grp;
        end
        for (int j = 0; j < 4; j++) begin
          byte_q[j] <= take ? mrg[j+5] : mrg[j];
        end
        for (int j = 4; j < 9; j++) begin
          byte_q[j] <= take ? 8'd0 : mrg[j];
        end
        // line end drops any residue after extraction
        cnt_q <= bus.in_line_end ? 4'd0 : rem;
      end
    end
  end

  assign bus.out_pix      = pix_q;
  assign bus.out_valid    = vld_q;
  assign bus.out_line_end = le_q;
  assign bus.err_partial  = err_q;
endmodule

// File: tb/tb_raw10_unpack.sv
// Directed bench for raw10_unpack with a byte-queue scoreboard.
// Covers 4-, 2- and 1-lane instances.
module tb_raw10_unpack;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  raw10_unpack_if #(.NUM_LANE(4)) i4 ();
  raw10_unpack_if #(.NUM_LANE(2)) i2 ();
  raw10_unpack_if #(.NUM_LANE(1)) i1 ();

  raw10_unpack #(.NUM_LANE(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (i4)
  );
  raw10_unpack #(.NUM_LANE(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (i2)
  );
  raw10_unpack #(.NUM_LANE(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (i1)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          sel = 4;
  logic [7:0]  mq[$];
  logic [39:0] sb[$];

  task automatic chk(string tag,
                     logic [39:0] obs,
                     logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic get_out(output logic [39:0] pix,
                         output logic ov,
                         output logic ole,
                         output logic oerr);
    case (sel)
      1: begin
        pix = i1.out_pix; ov = i1.out_valid;
        ole = i1.out_line_end; oerr = i1.err_partial;
      end
      2: begin
        pix = i2.out_pix; ov = i2.out_valid;
        ole = i2.out_line_end; oerr = i2.err_partial;
      end
      default: begin
        pix = i4.out_pix; ov = i4.out_valid;
        ole = i4.out_line_end; oerr = i4.err_partial;
      end
    endcase
  endtask

  // one cycle on the selected instance, then check it
  task automatic drive(bit v, logic [31:0] d, bit le);
    logic [7:0]  b[5];
    logic [39:0] pix;
    logic        ov, ole, oerr;
    bit          ev = 0, ele = 0, eerr = 0;
    i4.in_data     = d;
    i2.in_data     = d[15:0];
    i1.in_data     = d[7:0];
    i4.in_valid    = v && (sel == 4);
    i2.in_valid    = v && (sel == 2);
    i1.in_valid    = v && (sel == 1);
    i4.in_line_end = le;
    i2.in_line_end = le;
    i1.in_line_end = le;
    if (v) begin
      for (int k = 0; k < sel; k++) begin
        mq.push_back(d[8*k +: 8]);
      end
      if (mq.size() >= 5) begin
        for (int i = 0; i < 5; i++) b[i] = mq.pop_front();
        sb.push_back({b[3], b[4][7:6], b[2], b[4][5:4],
                      b[1], b[4][3:2], b[0], b[4][1:0]});
        ev = 1;
      end
      if (le) begin
        ele  = 1;
        eerr = (mq.size() != 0);
        mq.delete();
      end
    end
    @(posedge clk);
    #1;
    get_out(pix, ov, ole, oerr);
    chk("out_valid", 40'(ov), 40'(ev));
    if (ov === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL spurious_group observed=%h expected=none",
               pix);
      end else begin
        chk("out_pix", pix, sb.pop_front());
      end
    end
    chk("out_line_end", 40'(ole), 40'(ele));
    chk("err_partial", 40'(oerr), 40'(eerr));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, $urandom, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i4.in_valid = 0; i2.in_valid = 0; i1.in_valid = 0;
    @(posedge clk);
    #1;
    chk("rst_pix4", i4.out_pix, 40'd0);
    chk("rst_ctl4", {37'd0, i4.out_valid,
        i4.out_line_end, i4.err_partial}, 40'd0);
    chk("rst_ctl2", {i2.out_pix[36:0], i2.out_valid,
        i2.out_line_end, i2.err_partial}, 40'd0);
    chk("rst_ctl1", {i1.out_pix[36:0], i1.out_valid,
        i1.out_line_end, i1.err_partial}, 40'd0);
    rst = 1'b0;
    mq.delete();
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    i4.in_data = '0; i2.in_data = '0; i1.in_data = '0;
    i4.in_valid = 0; i2.in_valid = 0; i1.in_valid = 0;
    i4.in_line_end = 0; i2.in_line_end = 0;
    i1.in_line_end = 0;
    @(posedge clk);
    do_reset();

    // T1: known group, line ends with 3 leftover bytes
    sel = 4;
    drive(1, 32'h04030201, 0);
    drive(1, 32'hA5A5A5E4, 1);
    chk("t1_group", i4.out_pix,
        {10'h013, 10'h00E, 10'h009, 10'h004});
    idle(1);

    // T2: five back-to-back beats, no line end
    for (int i = 0; i < 5; i++) drive(1, $urandom, 0);
    chk("t2_count", 40'(u4.cnt_q), 40'(mq.size()));
    idle(1);

    // T3: 12 bytes, line end on third beat
    drive(1, $urandom, 0);
    drive(1, $urandom, 0);
    drive(1, $urandom, 1);

    // T4: gaps of 0, 1 and 3 cycles
    drive(1, $urandom, 0);
    drive(1, $urandom, 0);
    idle(1);
    drive(1, $urandom, 0);
    idle(3);
    drive(1, $urandom, 0);
    drive(1, $urandom, 1);
    idle(2);

    // T5: reset mid-line, then a clean 5-beat line
    for (int i = 0; i < 3; i++) drive(1, $urandom, 0);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, $urandom, 0);
    drive(1, $urandom, 1);
    idle(1);

    // T6: 10-byte lines on 1- and 2-lane instances
    sel = 1;
    for (int i = 0; i < 9; i++) drive(1, $urandom, 0);
    drive(1, $urandom, 1);
    idle(1);
    sel = 2;
    for (int i = 0; i < 4; i++) drive(1, $urandom, 0);
    drive(1, $urandom, 1);
    idle(1);
    sel = 2;
    drive(1, $urandom, 0);
    drive(1, $urandom, 0);
    drive(1, $urandom, 1);
    idle(1);

    chk("sb_drained", 40'(sb.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
